tetris_tick_scheduler: RTL
==========================

Name: tetris_tick_scheduler

Overview:
- Replaces the free-running gravity clock with a sequenced tick scheduler for the Tetris game core.
- Generates the fall tick with a level-dependent period, with optional soft-drop acceleration.
- Runs the lock-delay timer after a piece lands, waits for line clearing, and handles pause and game-over.
- Sits between the input/control logic and the piece-movement/board datapath.

Parameters:
- BASE_PERIOD, 32500000, fall period in Clk cycles at Level 0 (0.5 s at 65 MHz).
- LEVEL_STEP, 2000000, cycles removed from the period per level.
- MIN_PERIOD, 3250000, floor on the fall period.
- SOFT_PERIOD, 1625000, fall period while soft drop is active.
- LOCK_PERIOD, 16250000, lock-delay length in cycles.

Ports:
- Clk  input  1  65 MHz system clock
- Rst  input  1  synchronous reset, active-low (0 = reset)
- Start  input  1  start/restart pulse
- Pause  input  1  pause level
- Level  input  4  current level, 0..15
- Soft_Drop  input  1  soft-drop button level
- Landed  input  1  piece cannot move down
- Clear_Busy  input  1  board line-clear in progress
- Game_Over  input  1  spawn collision from board
- Fall_Tick  output  1  one-cycle pulse: move piece down one row
- Lock_Req  output  1  one-cycle pulse: lock piece into board
- Running  output  1  high in FALL/LOCK/WAIT_CLR
- State  output  3  encoded state, for debug

Behaviour:
- Reset (Rst=0 at posedge Clk): State=IDLE, counter=0, Fall_Tick=0, Lock_Req=0, Running=0, saved return state=FALL.
- Counter: 25 bits, registered outputs.
- Encoding: IDLE=0, FALL=1, LOCK=2, WAIT_CLR=3, PAUSED=4, OVER=5.
- Period: P = BASE_PERIOD - Level*LEVEL_STEP, computed 26-bit signed. If the result is < MIN_PERIOD, P = MIN_PERIOD. Level is sampled every cycle.
- Per-cycle priority: Rst > Game_Over > Pause > Landed > counter expiry.
- IDLE: Start=1 -> FALL, counter=0. All other inputs are ignored.
- FALL:
  - Counter increments each cycle.
  - When counter >= P-1: Fall_Tick=1 for exactly one cycle, counter=0. Using >= makes a shortened period (level up, soft drop) take effect at once with no wrap.
  - Landed=1 -> LOCK, counter=0, no Fall_Tick that cycle.
- LOCK:
  - Counter increments each cycle.
  - Landed=0 -> back to FALL, counter=0.
  - Counter == LOCK_PERIOD-1 -> Lock_Req=1 for one cycle, go to WAIT_CLR.
- WAIT_CLR:
  - The first cycle in the state ignores Clear_Busy.
  - From the second cycle, Clear_Busy=0 -> FALL, counter=0. Otherwise hold.
- PAUSED:
  - Entered from FALL or LOCK when Pause=1. Counter is frozen and the source state is saved.
  - Pause=0 -> return to the saved state; counting continues from the frozen value.
  - Pause is ignored in IDLE, WAIT_CLR and OVER.
  - No pulses are emitted while PAUSED.
- OVER: entered from any non-IDLE state when Game_Over=1. Stays there until Start=1, then goes to FALL with counter=0.
- Start while in FALL/LOCK/WAIT_CLR/PAUSED is ignored.
- Fall_Tick and Lock_Req are never high in the same cycle.

Optional Feature:
- Macro TETRIS_SOFT_DROP_EN.
- Defined: when Soft_Drop=1 in FALL, P = min(level period, SOFT_PERIOD).
- Undefined: the Soft_Drop port still exists but is ignored, and P is always the level period.

Test Plan:
Simulation overrides: BASE_PERIOD=20, LEVEL_STEP=2, MIN_PERIOD=4, SOFT_PERIOD=3, LOCK_PERIOD=5.
1. Rst=0 for 3 cycles, then Rst=1, Start pulse, Level=0 -> state FALL; Fall_Tick pulses every 20 cycles; Running=1.
2. Level=5 -> period 10. Level=15 -> 20-30 is negative, so period clamps to 4. Change Level from 0 to 5 when counter=15 -> Fall_Tick on the next cycle.
3. Landed=1 held -> LOCK, then Lock_Req on the 5th cycle. Clear_Busy=1 for 4 cycles -> FALL one cycle after it drops. Variant: Landed drops at lock cycle 3 -> FALL with no Lock_Req.
4. Pause=1 at FALL counter=7 for 50 cycles -> no pulses during the pause; after Pause=0, the tick arrives 13 cycles later.
5. Game_Over=1 during WAIT_CLR -> OVER, Running=0; Start -> FALL with counter=0. Rst=0 mid-LOCK -> IDLE next cycle with no Lock_Req.
6. With TETRIS_SOFT_DROP_EN defined: Soft_Drop=1 at Level 0 -> tick every 3 cycles. Without the macro: tick every 20 cycles.

Source files
------------

// File: rtl/tetris_tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tetris_tick_scheduler: fall/lock tick sequencer for the Tetris game core.  |
// | Optional soft drop is enabled by defining TETRIS_SOFT_DROP_EN.  Rev 1.0    |
// +----------------------------------------------------------------------------+
module tetris_tick_scheduler #(
  parameter int unsigned BASE_PERIOD = 32500000,
  parameter int unsigned LEVEL_STEP  = 2000000,
  parameter int unsigned MIN_PERIOD  = 3250000,
  parameter int unsigned SOFT_PERIOD = 1625000,
  parameter int unsigned LOCK_PERIOD = 16250000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Pause,
  input  logic [3:0] Level,
  input  logic       Soft_Drop,
  input  logic       Landed,
  input  logic       Clear_Busy,
  input  logic       Game_Over,
  output logic       Fall_Tick,
  output logic       Lock_Req,
  output logic       Running,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FALL     = 3'd1,
    ST_LOCK     = 3'd2,
    ST_WAIT_CLR = 3'd3,
    ST_PAUSED   = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  state_t        saved_q, saved_d;
  logic [24:0]   counter_q, counter_d;
  logic          fall_tick_q, fall_tick_d;
  logic          lock_req_q, lock_req_d;
  logic          running_q, running_d;

  logic [25:0]        level_dec;
  logic signed [25:0] period_raw;
  logic [25:0]        level_period;
  logic [25:0]        period;

  // Signed subtraction so high levels go negative and fall onto the floor.
  always_comb begin
    level_dec    = 26'(Level) * 26'(LEVEL_STEP);
    period_raw   = $signed(26'(BASE_PERIOD)) - $signed(level_dec);
    if (period_raw < $signed(26'(MIN_PERIOD))) begin
      level_period = 26'(MIN_PERIOD);
    end else begin
      level_period = $unsigned(period_raw);
    end
    period = level_period;
`ifdef TETRIS_SOFT_DROP_EN
    if (Soft_Drop && (level_period > 26'(SOFT_PERIOD))) begin
      period = 26'(SOFT_PERIOD);
    end
`endif
  end

`ifndef TETRIS_SOFT_DROP_EN
  logic unused_soft;
  assign unused_soft = Soft_Drop | (SOFT_PERIOD == 0);
`endif

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    counter_d   = counter_q;
    fall_tick_d = 1'b0;
    lock_req_d  = 1'b0;
    if (Game_Over && (state_q != ST_IDLE)) begin
      state_d   = ST_OVER;
      counter_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (Start) begin
            state_d   = ST_FALL;
            counter_d = '0;
          end
        end
        ST_FALL: begin
          if (Pause) begin
            state_d = ST_PAUSED;
            saved_d = ST_FALL;
          end else if (Landed) begin
            state_d   = ST_LOCK;
            counter_d = '0;
          end else if ({1'b0, counter_q} >= (period - 26'd1)) begin
            // >= lets a shortened period take effect immediately.
            fall_tick_d = 1'b1;
            counter_d   = '0;
          end else begin
            counter_d = counter_q + 25'd1;
          end
        end
        ST_LOCK: begin
          if (Pause) begin
            state_d = ST_PAUSED;
            saved_d = ST_LOCK;
          end else if (!Landed) begin
            state_d   = ST_FALL;
            counter_d = '0;
          end else if (counter_q == 25'(LOCK_PERIOD - 1)) begin
            lock_req_d = 1'b1;
            state_d    = ST_WAIT_CLR;
            counter_d  = '0;
          end else begin
            counter_d = counter_q + 25'd1;
          end
        end
        ST_WAIT_CLR: begin
          // Counter doubles as the first-cycle flag; the board sees Lock_Req late.
          if (counter_q == '0) begin
            counter_d = 25'd1;
          end else if (!Clear_Busy) begin
            state_d   = ST_FALL;
            counter_d = '0;
          end
        end
        ST_PAUSED: begin
          if (!Pause) begin
            state_d = saved_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end
      endcase
    end
    running_d = (state_d == ST_FALL) || (state_d == ST_LOCK) ||
                (state_d == ST_WAIT_CLR);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      saved_q     <= ST_FALL;
      counter_q   <= '0;
      fall_tick_q <= 1'b0;
      lock_req_q  <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      counter_q   <= counter_d;
      fall_tick_q <= fall_tick_d;
      lock_req_q  <= lock_req_d;
      running_q   <= running_d;
    end
  end

  assign Fall_Tick = fall_tick_q;
  assign Lock_Req  = lock_req_q;
  assign Running   = running_q;
  assign State     = state_q;

endmodule
`default_nettype wire
